// File: rtl/div_pkg.sv
// Shared types for the sequential rounding divider: FSM encoding and rounding modes.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  // Code 3 is reserved and behaves exactly like truncation.
  typedef enum logic [1:0] {
    RM_TRUNC     = 2'd0,
    RM_HALF_UP   = 2'd1,
    RM_HALF_EVEN = 2'd2,
    RM_RSVD      = 2'd3
  } rmode_e;

endpackage

// File: rtl/div_round_dec.sv
// Combinational rounding decision: whether the truncated quotient must be bumped by one.
module div_round_dec
  import div_pkg::*;
#(
  parameter int D_W = 17
) (
  input  logic [D_W-1:0] r_i,
  input  logic [D_W-1:0] d_i,
  input  logic           q0_i,
  input  rmode_e         mode_i,
  output logic           inc_o
);

  // 2R needs one extra bit so the comparison against D never wraps.
  logic [D_W:0] two_r;
  logic [D_W:0] d_ext;

  assign two_r = {r_i, 1'b0};
  assign d_ext = {1'b0, d_i};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RM_HALF_UP:   inc_o = (two_r >= d_ext);
      RM_HALF_EVEN: inc_o = (two_r > d_ext) || ((two_r == d_ext) && q0_i);
      default:      inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/div_uint_round_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, with selectable quotient rounding.
module div_uint_round_seq
  import div_pkg::*;
#(
  parameter int Z_W = 32,
  parameter int D_W = 17
) (
  input  logic           Clk_i,
  input  logic           Rst_n_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [Z_W-1:0] z_i,
  input  logic [D_W-1:0] d_i,
  input  logic [1:0]     rmode_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [Z_W-1:0] q_o,
  output logic [D_W-1:0] r_o,
  output logic           rnd_inc_o,
  output logic           div0_o
);

  localparam int CNT_W = $clog2(Z_W + 1);
  localparam int RW    = D_W + 1;

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [Z_W-1:0]   q_r;     // dividend shift register, becomes the quotient
  logic [RW-1:0]    rem_r;
  logic [D_W-1:0]   d_r;
  rmode_e           mode_r;
  logic             inc_r;
  logic             div0_r;

  logic             accept;
  logic             calc_last;
  logic [RW:0]      shifted;
  logic             fits;
  logic [RW-1:0]    rem_nxt;
  logic             round_inc;

  assign accept    = in_valid_i && (state == IDLE);
  assign calc_last = (cnt == CNT_W'(Z_W - 1));

  // Shift the next dividend bit into the partial remainder and trial-subtract D.
  assign shifted = {rem_r, q_r[Z_W-1]};
  assign fits    = (shifted >= {2'b00, d_r});
  assign rem_nxt = fits ? RW'(shifted - {2'b00, d_r}) : shifted[RW-1:0];

  div_round_dec #(.D_W(D_W)) u_round_dec (
    .r_i    (rem_r[D_W-1:0]),
    .d_i    (d_r),
    .q0_i   (q_r[0]),
    .mode_i (mode_r),
    .inc_o  (round_inc)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (d_i == '0) ? DONE : CALC;
      CALC:  if (calc_last) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      cnt    <= '0;
      q_r    <= '0;
      rem_r  <= '0;
      d_r    <= '0;
      mode_r <= RM_TRUNC;
      inc_r  <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          d_r    <= d_i;
          mode_r <= rmode_e'(rmode_i);
          cnt    <= '0;
          inc_r  <= 1'b0;
          if (d_i == '0) begin
            q_r    <= '1;
            rem_r  <= {1'b0, z_i[D_W-1:0]};
            div0_r <= 1'b1;
          end else begin
            q_r    <= z_i;
            rem_r  <= '0;
            div0_r <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= rem_nxt;
          q_r   <= {q_r[Z_W-2:0], fits};
          cnt   <= cnt + 1'b1;
        end
        ROUND: begin
          // An increment implies D >= 2, so the quotient cannot wrap here.
          q_r   <= q_r + Z_W'(round_inc);
          inc_r <= round_inc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign q_o         = out_valid_o ? q_r            : '0;
  assign r_o         = out_valid_o ? rem_r[D_W-1:0] : '0;
  assign rnd_inc_o   = out_valid_o && inc_r;
  assign div0_o      = out_valid_o && div0_r;

endmodule

// File: tb/tb_div_uint_round_seq.sv
// Directed self-checking bench for div_uint_round_seq at Z_W=32, D_W=17.
module tb_div_uint_round_seq;

  logic        Clk_i = 1'b0;
  logic        Rst_n_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] z_i = '0;
  logic [16:0] d_i = '0;
  logic [1:0]  rmode_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] q_o;
  logic [16:0] r_o;
  logic        rnd_inc_o;
  logic        div0_o;

  int checks = 0;
  int failures = 0;

  div_uint_round_seq #(.Z_W(32), .D_W(17)) dut (
    .Clk_i       (Clk_i),
    .Rst_n_i     (Rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .z_i         (z_i),
    .d_i         (d_i),
    .rmode_i     (rmode_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .q_o         (q_o),
    .r_o         (r_o),
    .rnd_inc_o   (rnd_inc_o),
    .div0_o      (div0_o)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Latency is counted in rising edges after the accept edge until out_valid is seen,
  // i.e. the accept cycle is cycle 0 and DONE is cycle lat+1.
  task automatic do_op(input string tag, input logic [31:0] z, input logic [16:0] d,
                       input logic [1:0] m, input logic [31:0] eq, input logic [16:0] er,
                       input logic einc, input logic ediv0, input int elat, input int stall);
    int n;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge Clk_i);
      n++;
    end
    @(negedge Clk_i);
    in_valid_i = 1'b1;
    z_i = z;
    d_i = d;
    rmode_i = m;
    @(posedge Clk_i);
    #1;
    // Keep requesting with different operands while busy: must be ignored.
    z_i = ~z;
    d_i = d ^ 17'h15a5a;
    rmode_i = ~m;
    n = 0;
    @(negedge Clk_i);
    while (!out_valid_o && n < 200) begin
      n++;
      @(negedge Clk_i);
    end
    in_valid_i = 1'b0;
    check({tag, ".lat"}, 64'(n), 64'(elat));
    check({tag, ".q"}, 64'(q_o), 64'(eq));
    check({tag, ".r"}, 64'(r_o), 64'(er));
    check({tag, ".inc"}, 64'(rnd_inc_o), 64'(einc));
    check({tag, ".div0"}, 64'(div0_o), 64'(ediv0));
    check({tag, ".busy"}, 64'(in_ready_o), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge Clk_i);
      check({tag, ".hold_v"}, 64'(out_valid_o), 64'd1);
      check({tag, ".hold_q"}, 64'(q_o), 64'(eq));
      check({tag, ".hold_r"}, 64'(r_o), 64'(er));
      check({tag, ".hold_rdy"}, 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    @(posedge Clk_i);
    #1;
    out_ready_i = 1'b0;
    check({tag, ".rdy_after"}, 64'(in_ready_o), 64'd1);
    check({tag, ".v_after"}, 64'(out_valid_o), 64'd0);
    check({tag, ".q_after"}, 64'(q_o), 64'd0);
  endtask

  initial begin
    #12;
    check("rst.ready", 64'(in_ready_o), 64'd1);
    check("rst.valid", 64'(out_valid_o), 64'd0);
    check("rst.q", 64'(q_o), 64'd0);
    check("rst.r", 64'(r_o), 64'd0);
    @(negedge Clk_i);
    Rst_n_i = 1'b1;

    do_op("z100_d7_hu",  32'd100,        17'd7,       2'd1, 32'd14,         17'd2,     1'b0, 1'b0, 33, 0);
    do_op("z5_d2_tr",    32'd5,          17'd2,       2'd0, 32'd2,          17'd1,     1'b0, 1'b0, 33, 0);
    do_op("z5_d2_hu",    32'd5,          17'd2,       2'd1, 32'd3,          17'd1,     1'b1, 1'b0, 33, 0);
    do_op("z5_d2_he",    32'd5,          17'd2,       2'd2, 32'd2,          17'd1,     1'b0, 1'b0, 33, 0);
    do_op("z7_d2_he",    32'd7,          17'd2,       2'd2, 32'd4,          17'd1,     1'b1, 1'b0, 33, 0);
    do_op("z5_d2_rsvd",  32'd5,          17'd2,       2'd3, 32'd2,          17'd1,     1'b0, 1'b0, 33, 0);
    do_op("zmax_dmax",   32'hFFFF_FFFF,  17'h1FFFF,   2'd1, 32'd32768,      17'd32767, 1'b0, 1'b0, 33, 0);
    do_op("zmax_d1",     32'hFFFF_FFFF,  17'd1,       2'd1, 32'hFFFF_FFFF,  17'd0,     1'b0, 1'b0, 33, 0);
    do_op("div0",        32'h1234,       17'd0,       2'd1, 32'hFFFF_FFFF,  17'h1234,  1'b0, 1'b1, 0,  0);
    do_op("stall",       32'd100,        17'd7,       2'd0, 32'd14,         17'd2,     1'b0, 1'b0, 33, 10);

    // Asynchronous reset in the middle of CALC discards the operation.
    @(negedge Clk_i);
    in_valid_i = 1'b1;
    z_i = 32'd1000;
    d_i = 17'd3;
    rmode_i = 2'd1;
    @(posedge Clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (15) @(posedge Clk_i);
    @(negedge Clk_i);
    check("mid.ready", 64'(in_ready_o), 64'd0);
    Rst_n_i = 1'b0;
    #1;
    check("arst.ready", 64'(in_ready_o), 64'd1);
    check("arst.valid", 64'(out_valid_o), 64'd0);
    check("arst.q", 64'(q_o), 64'd0);
    check("arst.r", 64'(r_o), 64'd0);
    check("arst.flags", 64'({rnd_inc_o, div0_o}), 64'd0);
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    do_op("z9_d4_hu",    32'd9,          17'd4,       2'd1, 32'd2,          17'd1,     1'b0, 1'b0, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
